// File: rtl/d_flip_flop_pkg.sv
// rtl/d_flip_flop_pkg.sv - shared width and data type for the d_flip_flop register bank
package d_flip_flop_pkg;

  localparam int DFF_DEFAULT_WIDTH = 4;

  typedef logic [DFF_DEFAULT_WIDTH-1:0] dff_data_t;

endpackage

// File: rtl/dff_bit.sv
// rtl/dff_bit.sv - single enabled D flip-flop with synchronous reset to a supplied bit
// Optional synchronous clear when D_FLIP_FLOP_CLEAR_EN is defined.
module dff_bit
  import d_flip_flop_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic reset_value,
`ifdef D_FLIP_FLOP_CLEAR_EN
  input  logic clear,
`endif
  input  logic d,
  output logic q
);

  // Priority: reset, then clear (when built in), then load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= reset_value;
    end
`ifdef D_FLIP_FLOP_CLEAR_EN
    else if (clear) begin
      q <= 1'b0;
    end
`endif
    else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - WIDTH-bit enabled data register with true and complement outputs
// Optional synchronous clear port when D_FLIP_FLOP_CLEAR_EN is defined.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
`ifdef D_FLIP_FLOP_CLEAR_EN
  input  logic             clear,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit u_bit (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .reset_value (RESET_VALUE[i]),
`ifdef D_FLIP_FLOP_CLEAR_EN
      .clear       (clear),
`endif
      .d           (data[i]),
      .q           (q[i])
    );
  end

  // Complement comes from the same register so q and q_bar can never agree.
  assign q_bar = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - scoreboard bench for d_flip_flop (clear tests when D_FLIP_FLOP_CLEAR_EN is defined)
module tb_d_flip_flop;

  localparam int WIDTH = 4;
`ifdef D_FLIP_FLOP_CLEAR_EN
  localparam logic [WIDTH-1:0] RV = 4'b1010;
`else
  localparam logic [WIDTH-1:0] RV = 4'b0000;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;

  logic [WIDTH-1:0] model_q = 'x;
  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;

  d_flip_flop #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .data   (data),
`ifdef D_FLIP_FLOP_CLEAR_EN
    .clear  (clear),
`endif
    .q      (q),
    .q_bar  (q_bar)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs and push the value q must show after the next edge.
  task automatic drive(input logic r, input logic en, input logic clr, input logic [WIDTH-1:0] d);
    reset  = r;
    enable = en;
    clear  = clr;
    data   = d;
    if (r)
      model_q = RV;
`ifdef D_FLIP_FLOP_CLEAR_EN
    else if (clr)
      model_q = '0;
`endif
    else if (en)
      model_q = d;
    exp_q.push_back(model_q);
  endtask

  initial begin : monitor
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q", q, e);
        check("q_bar", q_bar, ~e);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk); drive(1, 0, 0, 4'b1010);
    @(negedge clk); drive(1, 0, 0, 4'b1010);
    @(negedge clk); drive(0, 0, 0, 4'b1010);
    @(negedge clk); drive(0, 1, 0, 4'b1010);
    @(negedge clk); drive(0, 1, 0, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(0, 0, 0, 4'b0011);
      // Mid-cycle enable/data glitch must not reach q.
      #1 enable = 1'b1; data = 4'b1111;
      #1 check("glitch_q", q, 4'b0101);
      #1 enable = 1'b0; data = 4'b0011;
    end
    @(negedge clk); drive(0, 1, 0, 4'b1100);
    @(negedge clk); drive(1, 1, 0, 4'b1111);
    @(negedge clk); drive(0, 1, 0, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(0, ($urandom_range(0, 1) == 1), 0, WIDTH'($urandom));
    end
`ifdef D_FLIP_FLOP_CLEAR_EN
    @(negedge clk); drive(0, 1, 1, 4'b0110);
    @(negedge clk); drive(0, 1, 0, 4'b0110);
    @(negedge clk); drive(1, 1, 1, 4'b0110);
    @(negedge clk); drive(0, 0, 1, 4'b1111);
`endif
    @(negedge clk); drive(0, 0, 0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Parameterised bank of WIDTH D flip-flops sharing one clock, one load enable and one synchronous active-high reset.
- Provides a true output q and a complementary output q_bar.
- General-purpose enabled data register used wherever a multi-bit value is captured and held.
- Default width is 4 bits.

Parameters:
- WIDTH, 4, number of data bits stored.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock; all state changes occur on it.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  load enable; when high, data is captured on the rising clk edge.
- data  input  WIDTH  value to capture.
- q  output  WIDTH  registered value.
- q_bar  output  WIDTH  bitwise complement of q.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk and reset).
- All updates occur on the rising edge of clk only. No asynchronous paths into state.
- Priority at each rising edge: reset, then enable, then hold.
  - reset=1: q <= RESET_VALUE, regardless of enable or data.
  - reset=0, enable=1: q <= data.
  - reset=0, enable=0: q holds its value.
- Latency: data sampled at edge N appears on q immediately after edge N (1-cycle capture, no additional pipeline).
- q_bar equals ~q at all times, combinationally derived from the single q register. There is no separate q_bar register, and q and q_bar are never equal on any bit.
- Changes on data or enable between clock edges have no effect on q.
- Reset mid-operation: q returns to RESET_VALUE at the first edge with reset high. Loads resume at the first edge after reset deasserts with enable high.
- Reset and enable both high: reset wins.
- Before the first reset, q is undefined. The bench must apply reset before checking.
- All WIDTH bits are loaded together; there are no per-bit enables.

Optional Feature:
- Macro: D_FLIP_FLOP_CLEAR_EN.
- When defined:
  - Adds input port clear (1 bit), a synchronous active-high clear.
  - At a rising edge, clear=1 forces q <= 0, independent of RESET_VALUE.
  - Priority: reset > clear > enable > hold.
- When undefined:
  - No clear port exists.
  - Behaviour is exactly as above.

Decomposition:
- Shared package d_flip_flop_pkg:
  - localparam DFF_DEFAULT_WIDTH = 4.
  - Typedef dff_data_t (logic [DFF_DEFAULT_WIDTH-1:0]) for default-width users.
- Sub-module dff_bit: single-bit enabled DFF with synchronous reset, a reset-value input bit and the optional clear.
  - d_flip_flop instantiates WIDTH copies via a generate loop and derives q_bar = ~q.

Test Plan:
- Clock period 10. Reset=1 for 2 edges with data=1010 and enable=0 -> q=0000, q_bar=1111.
- Reset=0, enable=0, data=1010 held for 1 edge -> q stays 0000. Raise enable=1 -> next edge q=1010, q_bar=0101.
- enable=1, data changes to 0101 -> next edge q=0101, q_bar=1010. Data glitches between edges -> no change on q.
- enable=0, data=0011 for 4 edges -> q holds 0101 throughout. Then enable=1, data=1100 -> next edge q=1100, q_bar=0011.
- With q=1100, assert reset=1 together with enable=1 and data=1111 -> next edge q=0000. Deassert reset -> following edge q=1111.
- With D_FLIP_FLOP_CLEAR_EN defined and RESET_VALUE=1010:
  - clear=1, enable=1, data=0110 -> q=0000.
  - reset=1 and clear=1 together -> q=1010.
